// File: rtl/aes_batch_sequencer_pkg.sv
// Shared definitions for the AES batch sequencer.
// Contents:
//   SEQ_ADDR_WIDTH - default width of block index / ROM / RAM addresses
//   seq_state_e    - sequencer FSM state encoding
//   lat_cnt_width  - width of the ROM-latency counter for a given latency
package aes_batch_sequencer_pkg;

    localparam int unsigned SEQ_ADDR_WIDTH = 32'd8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } seq_state_e;

    // A latency of 1 still needs a 1-bit counter so the FETCH logic stays uniform.
    function automatic int unsigned lat_cnt_width(input int unsigned lat);
        return (lat > 32'd1) ? $clog2(lat) : 32'd1;
    endfunction

endpackage

// File: rtl/aes_seq_watchdog.sv
// Core-completion watchdog for the AES batch sequencer.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   clr_i         - synchronous clear of the count (wins over en_i)
//   en_i          - count one cycle
//   expired_o     - high while the count equals TIMEOUT
// The count holds at TIMEOUT so it can never wrap back to a non-expired value.
module aes_seq_watchdog #(
    parameter int unsigned TO_WIDTH = 32'd8,
    parameter int unsigned TIMEOUT  = 32'd255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TO_WIDTH-1:0] count_r;

    assign expired_o = (count_r == TO_WIDTH'(TIMEOUT));

    // Watchdog count: clear, or advance while enabled and not yet expired.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= {TO_WIDTH{1'b0}};
        end else if (clr_i) begin
            count_r <= {TO_WIDTH{1'b0}};
        end else if (en_i && !expired_o) begin
            count_r <= count_r + TO_WIDTH'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/aes_batch_sequencer.sv
// Sequences a batch of AES-128 encryptions through the AES core.
// Per block: present the ROM address, launch the core, wait for completion
// under a watchdog, then write the core result into the cyphertext RAM.
// Ports:
//   clk_i, rst_ni             - clock, asynchronous active-low reset
//   start_i, num_blocks_i     - batch start request and block count (IDLE only)
//   abort_i                   - abandon the running batch
//   rom_addr_o                - plaintext/key ROM address (current index)
//   core_start_o, core_done_i - AES core launch pulse / completion
//   ram_we_o, ram_addr_o      - cyphertext RAM write strobe / address
//   busy_o                    - batch in progress
//   done_o, aborted_o         - one-cycle completion / abandon pulses
//   err_o                     - sticky core-timeout flag
//   blk_cnt_o                 - blocks written in current/last batch
module aes_batch_sequencer
    import aes_batch_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SEQ_ADDR_WIDTH,
    parameter int unsigned ROM_LAT    = 32'd1,
    parameter int unsigned TIMEOUT    = 32'd255,
    parameter int unsigned TO_WIDTH   = 32'd8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] num_blocks_i,
    input  logic                  abort_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    output logic                  core_start_o,
    input  logic                  core_done_i,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] blk_cnt_o
);

    localparam int unsigned     LAT_W    = lat_cnt_width(ROM_LAT);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT - 32'd1);

    seq_state_e            state_r;
    logic [ADDR_WIDTH-1:0] idx_r;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic [ADDR_WIDTH-1:0] blk_cnt_r;
    logic [LAT_W-1:0]      lat_r;
    logic                  core_start_r;
    logic                  ram_we_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  aborted_r;
    logic                  err_r;

    logic                  wd_clr_s;
    logic                  wd_en_s;
    logic                  wd_expired_s;
    logic                  last_blk_s;
    logic                  abort_s;

    assign wd_clr_s   = (state_r == ST_LAUNCH);
    assign wd_en_s    = (state_r == ST_WAIT);
    // cnt_r is never 0 outside IDLE/DONE, so cnt_r-1 does not underflow in WRITE.
    assign last_blk_s = (idx_r == (cnt_r - ADDR_WIDTH'(1'b1)));
    assign abort_s    = abort_i && (state_r != ST_IDLE);

    aes_seq_watchdog #(
        .TO_WIDTH (TO_WIDTH),
        .TIMEOUT  (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (wd_clr_s),
        .en_i      (wd_en_s),
        .expired_o (wd_expired_s)
    );

    // Batch FSM with index, block counter and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            idx_r        <= {ADDR_WIDTH{1'b0}};
            cnt_r        <= {ADDR_WIDTH{1'b0}};
            blk_cnt_r    <= {ADDR_WIDTH{1'b0}};
            lat_r        <= {LAT_W{1'b0}};
            core_start_r <= 1'b0;
            ram_we_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            core_start_r <= 1'b0;
            ram_we_r     <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
            if (abort_s) begin
                // Abort overrides whatever the current state would have done.
                state_r   <= ST_IDLE;
                busy_r    <= 1'b0;
                aborted_r <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start_i) begin
                            cnt_r     <= num_blocks_i;
                            idx_r     <= {ADDR_WIDTH{1'b0}};
                            blk_cnt_r <= {ADDR_WIDTH{1'b0}};
                            lat_r     <= {LAT_W{1'b0}};
                            err_r     <= 1'b0;
                            busy_r    <= 1'b1;
                            if (num_blocks_i == {ADDR_WIDTH{1'b0}}) begin
                                state_r <= ST_DONE;
                            end else begin
                                state_r <= ST_FETCH;
                            end
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_FETCH: begin
                        if (lat_r == LAT_LAST) begin
                            lat_r        <= {LAT_W{1'b0}};
                            core_start_r <= 1'b1;
                            state_r      <= ST_LAUNCH;
                        end else begin
                            lat_r <= lat_r + LAT_W'(1'b1);
                        end
                    end
                    ST_LAUNCH: begin
                        state_r <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        // Completion wins over a watchdog expiry in the same cycle.
                        if (core_done_i) begin
                            ram_we_r <= 1'b1;
                            state_r  <= ST_WRITE;
                        end else if (wd_expired_s) begin
                            state_r <= ST_ERR;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                    ST_WRITE: begin
                        blk_cnt_r <= blk_cnt_r + ADDR_WIDTH'(1'b1);
                        if (last_blk_s) begin
                            state_r <= ST_DONE;
                        end else begin
                            idx_r   <= idx_r + ADDR_WIDTH'(1'b1);
                            state_r <= ST_FETCH;
                        end
                    end
                    ST_DONE: begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    ST_ERR: begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rom_addr_o   = idx_r;
    assign ram_addr_o   = idx_r;
    assign core_start_o = core_start_r;
    // The strobe is registered on entry to WRITE; an abort arriving during the
    // WRITE cycle itself must still suppress the RAM write.
    assign ram_we_o     = ram_we_r && !abort_i;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign aborted_o    = aborted_r;
    assign err_o        = err_r;
    assign blk_cnt_o    = blk_cnt_r;

endmodule

// File: tb/tb_aes_batch_sequencer.sv
// Scoreboard bench for aes_batch_sequencer: the stimulus process queues the
// expected output events, a monitor on the falling edge pops and compares.
module tb_aes_batch_sequencer;

    logic       clk_i        = 1'b0;
    logic       rst_ni       = 1'b0;
    logic       start_i      = 1'b0;
    logic [7:0] num_blocks_i = 8'd0;
    logic       abort_i      = 1'b0;
    logic       core_done_i  = 1'b0;
    logic [7:0] rom_addr_o;
    logic       core_start_o;
    logic       ram_we_o;
    logic [7:0] ram_addr_o;
    logic       busy_o;
    logic       done_o;
    logic       aborted_o;
    logic       err_o;
    logic [7:0] blk_cnt_o;

    typedef enum logic [2:0] {
        EV_START = 3'd0,
        EV_WRITE = 3'd1,
        EV_DONE  = 3'd2,
        EV_ABORT = 3'd3,
        EV_ERR   = 3'd4
    } ev_kind_e;

    typedef struct packed {
        ev_kind_e   kind;
        logic [7:0] val;
    } ev_t;

    ev_t  exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic err_prev  = 1'b0;

    aes_batch_sequencer #(
        .ADDR_WIDTH (8),
        .ROM_LAT    (1),
        .TIMEOUT    (255),
        .TO_WIDTH   (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .num_blocks_i (num_blocks_i),
        .abort_i      (abort_i),
        .rom_addr_o   (rom_addr_o),
        .core_start_o (core_start_o),
        .core_done_i  (core_done_i),
        .ram_we_o     (ram_we_o),
        .ram_addr_o   (ram_addr_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .aborted_o    (aborted_o),
        .err_o        (err_o),
        .blk_cnt_o    (blk_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic observe(input ev_kind_e k, input logic [7:0] v);
        ev_t e;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_event: got kind %0d val %0d, expected no event", int'(k), v);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            check("event_val", int'(v), int'(e.val));
        end
    endtask

    // Monitor: turns output pulses into events and compares them in order.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (core_start_o)        observe(EV_START, rom_addr_o);
                if (ram_we_o)            observe(EV_WRITE, ram_addr_o);
                if (done_o)              observe(EV_DONE, blk_cnt_o);
                if (aborted_o)           observe(EV_ABORT, blk_cnt_o);
                if (err_o && !err_prev)  observe(EV_ERR, blk_cnt_o);
            end
            err_prev = err_o;
        end
    end

    task automatic push(input ev_kind_e k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = 8'(v);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_batch(input int n);
        num_blocks_i = 8'(n);
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
    endtask

    task automatic wait_launch();
        int n = 0;
        while (!core_start_o && n < 600) begin
            tick();
            n++;
        end
        check("launch_seen", int'(core_start_o), 1);
    endtask

    // Core model: completes `delay` cycles after the launch pulse.
    task automatic run_block(input int delay);
        wait_launch();
        repeat (delay) tick();
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        check("we_after_done", int'(ram_we_o), 1);
    endtask

    task automatic expect_done(input int blks);
        int n = 0;
        while (!done_o && n < 10) begin
            tick();
            n++;
        end
        check("done_pulse", int'(done_o), 1);
        check("busy_after_done", int'(busy_o), 0);
        check("blk_cnt_final", int'(blk_cnt_o), blks);
    endtask

    function automatic int all_outputs();
        return int'({rom_addr_o, core_start_o, ram_we_o, ram_addr_o, busy_o,
                     done_o, aborted_o, err_o, blk_cnt_o});
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running, expected finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("reset_outputs", all_outputs(), 0);
        rst_ni = 1'b1;
        tick();
        check("idle_after_reset", all_outputs(), 0);

        // Three-block batch, core finishes 40 cycles after each launch
        push(EV_START, 0); push(EV_WRITE, 0);
        push(EV_START, 1); push(EV_WRITE, 1);
        push(EV_START, 2); push(EV_WRITE, 2);
        push(EV_DONE, 3);
        start_batch(3);
        for (int b = 0; b < 3; b++) run_block(40);
        expect_done(3);
        repeat (2) tick();

        // Zero-block batch: DONE state one cycle after start, pulse the next
        push(EV_DONE, 0);
        start_batch(0);
        check("zero_done_early", int'(done_o), 0);
        check("zero_busy", int'(busy_o), 1);
        tick();
        check("zero_done_at_2", int'(done_o), 1);
        check("zero_busy_low", int'(busy_o), 0);
        check("zero_blk_cnt", int'(blk_cnt_o), 0);
        repeat (2) tick();

        // Timeout: WAIT spans watchdog values 0..255 (256 cycles after LAUNCH),
        // ERR follows, and err_o shows one cycle after ERR: launch + 258.
        push(EV_START, 0);
        push(EV_ERR, 0);
        start_batch(1);
        wait_launch();
        repeat (257) tick();
        check("err_not_yet", int'(err_o), 0);
        check("busy_in_err", int'(busy_o), 1);
        tick();
        check("err_set", int'(err_o), 1);
        check("busy_after_err", int'(busy_o), 0);
        check("no_done_on_err", int'(done_o), 0);
        repeat (3) tick();
        check("err_sticky", int'(err_o), 1);

        // Next start clears err_o and runs normally
        push(EV_START, 0); push(EV_WRITE, 0);
        push(EV_START, 1); push(EV_WRITE, 1);
        push(EV_DONE, 2);
        start_batch(2);
        check("err_cleared", int'(err_o), 0);
        for (int b = 0; b < 2; b++) run_block(3);
        expect_done(2);
        repeat (2) tick();

        // Abort coincident with core_done on block 1
        push(EV_START, 0); push(EV_WRITE, 0);
        push(EV_START, 1);
        push(EV_ABORT, 1);
        start_batch(4);
        run_block(5);
        wait_launch();
        repeat (5) tick();
        core_done_i = 1'b1;
        abort_i     = 1'b1;
        tick();
        core_done_i = 1'b0;
        abort_i     = 1'b0;
        check("abort_no_write", int'(ram_we_o), 0);
        check("abort_pulse", int'(aborted_o), 1);
        check("abort_busy_low", int'(busy_o), 0);
        check("abort_blk_cnt", int'(blk_cnt_o), 1);
        tick();
        check("abort_one_pulse", int'(aborted_o), 0);
        repeat (3) tick();

        // Asynchronous reset in the middle of WAIT on block 2
        push(EV_START, 0); push(EV_WRITE, 0);
        push(EV_START, 1); push(EV_WRITE, 1);
        push(EV_START, 2);
        start_batch(3);
        for (int b = 0; b < 2; b++) run_block(3);
        wait_launch();
        repeat (10) tick();
        #1;
        rst_ni = 1'b0;
        #1;
        check("async_reset_outputs", all_outputs(), 0);
        tick();
        rst_ni = 1'b1;
        tick();
        push(EV_START, 0); push(EV_WRITE, 0);
        push(EV_DONE, 1);
        start_batch(1);
        run_block(3);
        expect_done(1);
        repeat (2) tick();

        // Ignored inputs: core_done in FETCH, start re-pulsed during WAIT
        push(EV_START, 0); push(EV_WRITE, 0);
        push(EV_START, 1); push(EV_WRITE, 1);
        push(EV_DONE, 2);
        start_batch(2);
        core_done_i = 1'b1;
        check("no_launch_in_fetch", int'(core_start_o), 0);
        tick();
        core_done_i = 1'b0;
        check("launch_latency", int'(core_start_o), 1);
        repeat (5) tick();
        num_blocks_i = 8'd7;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        check("busy_in_wait", int'(busy_o), 1);
        repeat (3) tick();
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        check("we_block0", int'(ram_we_o), 1);
        run_block(4);
        expect_done(2);

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
